// File: rtl/io_port_unit.sv
// FIFO-buffered CPU input/output port pair with sticky error flags, occupancy and display hold word.
// Device side is valid/ready; the CPU side is pop/push strobes. bus_out is combinational from registered state only.
module io_port_unit #(
  parameter int          WIDTH     = 32,
  parameter int          IN_DEPTH  = 4,
  parameter int          OUT_DEPTH = 4,
  parameter int          IN_MODE   = 1,
  parameter logic [31:0] INIT      = 32'h000000C0
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         in_pop,
  output logic [WIDTH-1:0]             bus_out,
  input  logic                         out_push,
  input  logic [WIDTH-1:0]             bus_in,
  input  logic [WIDTH-1:0]             dev_in_data,
  input  logic                         dev_in_valid,
  output logic                         dev_in_ready,
  output logic [WIDTH-1:0]             dev_out_data,
  output logic                         dev_out_valid,
  input  logic                         dev_out_ready,
  output logic [WIDTH-1:0]             last_out,
  output logic [$clog2(IN_DEPTH):0]    in_count,
  output logic [$clog2(OUT_DEPTH):0]   out_count,
  output logic                         in_underflow,
  output logic                         out_overflow,
  input  logic                         flag_clr
);
  localparam int IAW = $clog2(IN_DEPTH);
  localparam int OAW = $clog2(OUT_DEPTH);
  localparam logic [IAW:0] IN_FULL  = (IAW+1)'(IN_DEPTH);
  localparam logic [OAW:0] OUT_FULL = (OAW+1)'(OUT_DEPTH);
  localparam bit FIFO_IN = (IN_MODE != 0);

  logic [WIDTH-1:0] r_in_mem  [IN_DEPTH];
  logic [WIDTH-1:0] r_out_mem [OUT_DEPTH];
  logic [IAW-1:0]   r_in_wp, r_in_rp;
  logic [OAW-1:0]   r_out_wp, r_out_rp;
  logic [IAW:0]     r_in_cnt;
  logic [OAW:0]     r_out_cnt;
  logic [WIDTH-1:0] r_hold, r_last;
  logic             r_unf, r_ovf;

  logic w_in_empty, w_in_wr, w_in_rd, w_in_unf;
  logic w_out_full, w_out_rd, w_out_wr, w_out_ovf;

  assign w_in_empty   = (r_in_cnt == '0);
  assign dev_in_ready = FIFO_IN ? (r_in_cnt != IN_FULL) : 1'b1;
  assign w_in_wr      = FIFO_IN && dev_in_valid && (r_in_cnt != IN_FULL);
  assign w_in_rd      = FIFO_IN && in_pop && !w_in_empty;
  assign w_in_unf     = FIFO_IN && in_pop && w_in_empty;
  assign bus_out      = (FIFO_IN && !w_in_empty) ? r_in_mem[r_in_rp] : r_hold;

  // A full output FIFO still accepts a push when the device drains the head in the same cycle.
  assign w_out_full   = (r_out_cnt == OUT_FULL);
  assign w_out_rd     = (r_out_cnt != '0) && dev_out_ready;
  assign w_out_wr     = out_push && (!w_out_full || w_out_rd);
  assign w_out_ovf    = out_push && w_out_full && !w_out_rd;

  assign dev_out_valid = (r_out_cnt != '0);
  assign dev_out_data  = r_out_mem[r_out_rp];
  assign last_out      = r_last;
  assign in_count      = r_in_cnt;
  assign out_count     = r_out_cnt;
  assign in_underflow  = r_unf;
  assign out_overflow  = r_ovf;

  always_ff @(posedge clock) begin
    if (reset && w_in_wr)  r_in_mem[r_in_wp]   <= dev_in_data;
    if (reset && w_out_wr) r_out_mem[r_out_wp] <= bus_in;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_in_wp   <= '0;
      r_in_rp   <= '0;
      r_in_cnt  <= '0;
      r_out_wp  <= '0;
      r_out_rp  <= '0;
      r_out_cnt <= '0;
      r_hold    <= INIT[WIDTH-1:0];
      r_last    <= '0;
      r_unf     <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      if (w_in_wr) r_in_wp <= r_in_wp + IAW'(1);
      if (w_in_rd) begin
        r_in_rp <= r_in_rp + IAW'(1);
        r_hold  <= r_in_mem[r_in_rp];
      end else if (!FIFO_IN && dev_in_valid) begin
        r_hold  <= dev_in_data;
      end
      case ({w_in_wr, w_in_rd})
        2'b10:   r_in_cnt <= r_in_cnt + (IAW+1)'(1);
        2'b01:   r_in_cnt <= r_in_cnt - (IAW+1)'(1);
        default: r_in_cnt <= r_in_cnt;
      endcase

      if (w_out_wr) begin
        r_out_wp <= r_out_wp + OAW'(1);
        r_last   <= bus_in;
      end
      if (w_out_rd) r_out_rp <= r_out_rp + OAW'(1);
      case ({w_out_wr, w_out_rd})
        2'b10:   r_out_cnt <= r_out_cnt + (OAW+1)'(1);
        2'b01:   r_out_cnt <= r_out_cnt - (OAW+1)'(1);
        default: r_out_cnt <= r_out_cnt;
      endcase

      // Set has priority over clear.
      if (w_in_unf)      r_unf <= 1'b1;
      else if (flag_clr) r_unf <= 1'b0;
      if (w_out_ovf)     r_ovf <= 1'b1;
      else if (flag_clr) r_ovf <= 1'b0;
    end
  end
endmodule
